// File: rtl/fetch_buffer_stage.sv
// Fetch buffer between the PCF register and decode: issues in-order instruction
// memory requests under a credit limit and buffers tagged responses in a show-ahead FIFO.
module fetch_buffer_stage #(
    parameter int DPW   = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DPW-1:0] PCF,
    input  logic           flushD,
    input  logic           stallD,
    output logic           imem_req,
    output logic [DPW-1:0] imem_addr,
    input  logic           imem_gnt,
    input  logic           imem_rvalid,
    input  logic [DPW-1:0] imem_rdata,
    output logic           stallF_o,
    output logic           validD,
    output logic [DPW-1:0] InstrD,
    output logic [DPW-1:0] PCD,
    output logic [DPW-1:0] PCPlus4D
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [DPW-1:0] NOP     = DPW'(32'h0000_0013);
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

    logic           r_rst_done;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_outst;
    logic [CW-1:0]  r_discard;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_tag_rd;
    logic [PW-1:0]  r_tag_wr;
    logic [DPW-1:0] r_last_pc;
    logic [DPW-1:0] r_fifo_pc    [DEPTH];
    logic [DPW-1:0] r_fifo_instr [DEPTH];
    logic [DPW-1:0] r_tag        [DEPTH];

    logic           w_credit;
    logic           w_accept;
    logic           w_resp;
    logic           w_keep;
    logic           w_pop;
    logic [DPW-1:0] w_head_pc;

    // Handshakes: a request transfers on a cycle with imem_req && imem_gnt; a response
    // transfers on any imem_rvalid cycle; decode consumes the head on validD && !stallD.
    assign w_credit  = ({1'b0, r_outst} + {1'b0, r_count}) < DEPTH_C;
    assign imem_req  = rst_n && r_rst_done && !flushD && w_credit;
    assign imem_addr = PCF;
    assign w_accept  = imem_req && imem_gnt;
    assign stallF_o  = !w_accept;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp = imem_rvalid && (r_outst != '0);
    assign w_keep = w_resp && (r_discard == '0) && !flushD;

    assign validD    = (r_count != '0);
    assign w_pop     = validD && !stallD && !flushD;
    assign w_head_pc = r_fifo_pc[r_rd_ptr];
    assign InstrD    = validD ? r_fifo_instr[r_rd_ptr] : NOP;
    assign PCD       = validD ? w_head_pc : r_last_pc;
    assign PCPlus4D  = PCD + DPW'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
            r_count    <= '0;
            r_outst    <= '0;
            r_discard  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
            r_last_pc  <= '0;
        end else begin
            r_rst_done <= 1'b1;
            r_outst    <= r_outst + CW'(w_accept) - CW'(w_resp);
            if (w_accept) r_tag_wr <= r_tag_wr + PW'(1);
            if (w_resp)   r_tag_rd <= r_tag_rd + PW'(1);
            if (validD)   r_last_pc <= w_head_pc;

            // Every response still in flight after a flush belongs to the old path.
            if (flushD)
                r_discard <= r_outst - CW'(w_resp);
            else if (w_resp && (r_discard != '0))
                r_discard <= r_discard - CW'(1);

            if (flushD) begin
                r_count  <= '0;
                r_rd_ptr <= r_wr_ptr;
            end else begin
                r_count <= r_count + CW'(w_keep) - CW'(w_pop);
                if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_keep) r_wr_ptr <= r_wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_tag[r_tag_wr] <= PCF;
        if (w_keep) begin
            r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Randomized bench for fetch_buffer_stage: an in-order memory model with variable
// latency, a queue of fetched PCs as the expected decode stream, and a decode monitor.
module tb_fetch_buffer_stage;
    localparam int DPW   = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DPW-1:0] PCF;
    logic           flushD;
    logic           stallD;
    logic           imem_req;
    logic [DPW-1:0] imem_addr;
    logic           imem_gnt;
    logic           imem_rvalid;
    logic [DPW-1:0] imem_rdata;
    logic           stallF_o;
    logic           validD;
    logic [DPW-1:0] InstrD;
    logic [DPW-1:0] PCD;
    logic [DPW-1:0] PCPlus4D;

    always #5 clk = ~clk;

    fetch_buffer_stage #(.DPW(DPW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .flushD(flushD), .stallD(stallD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stallF_o(stallF_o),
        .validD(validD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          live;
    } mreq_t;

    mreq_t          mem_q[$];
    logic [DPW-1:0] exp_q[$];
    int unsigned    n_vec = 0;
    int unsigned    n_err = 0;
    int unsigned    cyc = 0;
    int unsigned    n_pops = 0;
    int             buffered = 0;
    bit             rst_done_m = 1'b0;
    logic [31:0]    pcf_m = '0;
    logic [31:0]    flush_target = '0;
    int unsigned    gnt_pct = 100;
    int unsigned    stall_pct = 0;
    int unsigned    flush_pct = 0;
    int unsigned    lat_min = 1;
    int unsigned    lat_max = 1;
    bit             rst_drive = 1'b0;
    bit             stale_rv = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s @cyc %0d: wait bound expired", name, cyc);
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then advance the model
    // to the state the DUT will hold after the next rising edge.
    task automatic step(input bit flush);
        bit    exp_req;
        bit    acc;
        bit    pop;
        mreq_t r;
        @(negedge clk);
        cyc++;
        rst_n    = rst_drive;
        flushD   = flush;
        stallD   = ($urandom_range(99) < stall_pct);
        imem_gnt = ($urandom_range(99) < gnt_pct);
        PCF      = pcf_m;
        if (stale_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        if (!rst_n) begin
            check("rst_validD", validD, 0);
            check("rst_imem_req", imem_req, 0);
            check("rst_stallF", stallF_o, 1);
            check("rst_InstrD", InstrD, NOP);
            check("rst_PCD", PCD, 0);
            check("rst_PCPlus4D", PCPlus4D, 4);
            mem_q.delete();
            exp_q.delete();
            buffered   = 0;
            rst_done_m = 1'b0;
            pcf_m      = '0;
        end else begin
            exp_req = !flush && rst_done_m && (mem_q.size() + buffered < DEPTH);
            check("imem_req", imem_req, exp_req);
            check("stallF_o", stallF_o, !(exp_req && imem_gnt));
            check("validD", validD, buffered != 0);
            if (imem_req) check("imem_addr", imem_addr, PCF);
            check("credit_bound", mem_q.size() + buffered <= DEPTH, 1);
            acc = imem_req && imem_gnt;
            pop = validD && !stallD && !flush;
            if (imem_rvalid && !stale_rv) begin
                r = mem_q.pop_front();
                if (r.live && !flush) buffered++;
            end
            if (pop) buffered--;
            if (acc) begin
                r.addr = PCF;
                r.due  = cyc + $urandom_range(lat_max, lat_min);
                r.live = 1'b1;
                mem_q.push_back(r);
                exp_q.push_back(PCF);
            end
            if (flush) begin
                buffered = 0;
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
                exp_q.delete();
                pcf_m = flush_target;
            end else if (acc) begin
                pcf_m = pcf_m + 32'd4;
            end
            rst_done_m = 1'b1;
        end
    endtask

    // Decode-side monitor: every instruction consumed must be the oldest surviving fetch.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && validD && !stallD && !flushD) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL decode_extra @cyc %0d: got PCD %h, expected no instruction", cyc, PCD);
                end else begin
                    e = exp_q.pop_front();
                    check("PCD", PCD, e);
                    check("InstrD", InstrD, mem_word(e));
                    check("PCPlus4D", PCPlus4D, e + 32'd4);
                    n_pops++;
                end
            end
        end
    end

    initial begin
        int unsigned wait_cnt;
        int unsigned start_pops;
        flushD = 1'b0; stallD = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; PCF = '0;

        repeat (3) step(0);
        rst_drive = 1'b1;
        repeat (20) step(0);

        gnt_pct = 0;
        repeat (3) step(0);
        gnt_pct = 100;
        repeat (6) step(0);

        stall_pct = 100;
        repeat (10) step(0);
        stall_pct = 0;
        repeat (12) step(0);

        // Flush with three or more requests in flight and a response landing that cycle.
        lat_min = 4; lat_max = 4;
        wait_cnt = 0;
        while (!(mem_q.size() >= 3 && mem_q[0].due == cyc + 1) && wait_cnt < 50) begin
            step(0);
            wait_cnt++;
        end
        if (wait_cnt >= 50) timeout("flush_setup");
        flush_target = 32'h0000_0100;
        step(1);
        repeat (25) step(0);

        // Redirect near the top of the address space so PCPlus4D wraps.
        lat_min = 1; lat_max = 2;
        flush_target = 32'hFFFF_FFF8;
        step(1);
        repeat (15) step(0);

        lat_min = 1; lat_max = 4;
        gnt_pct = 70; stall_pct = 30; flush_pct = 3;
        start_pops = n_pops;
        wait_cnt = 0;
        while (n_pops - start_pops < 200 && wait_cnt < 3000) begin
            flush_target = $urandom & 32'hFFFF_FFFC;
            step($urandom_range(99) < flush_pct);
            wait_cnt++;
        end
        if (wait_cnt >= 3000) timeout("random_stream");
        flush_pct = 0;

        // Mid-stream reset with work both in flight and buffered; stale responses follow.
        lat_min = 3; lat_max = 3;
        gnt_pct = 100; stall_pct = 100;
        wait_cnt = 0;
        while (!(mem_q.size() >= 2 && buffered >= 2) && wait_cnt < 50) begin
            step(0);
            wait_cnt++;
        end
        if (wait_cnt >= 50) timeout("reset_setup");
        rst_drive = 1'b0;
        stale_rv  = 1'b1;
        repeat (2) step(0);
        rst_drive = 1'b1;
        step(0);
        stale_rv  = 1'b0;
        stall_pct = 0;
        lat_min = 1; lat_max = 3;
        repeat (20) step(0);

        gnt_pct = 0;
        wait_cnt = 0;
        while ((mem_q.size() != 0 || buffered != 0) && wait_cnt < 200) begin
            step(0);
            wait_cnt++;
        end
        if (wait_cnt >= 200) timeout("drain");
        step(0);
        check("drain_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
